data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 147 ++++++++++++++
 tb/tb_data_memory_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: line-oriented (128-bit) data memory behind a cache.
// Each transaction stalls the requester for LATENCY+1 cycles, then releases
// it for one DONE cycle. Out-of-range addresses complete with ERROR=1 and
// READDATA=0. The optional per-byte write mask is enabled by defining
// DMEM_BYTEEN_EN; the default build always writes the full line.
module data_memory_responder #(
    parameter int unsigned BLOCK_ADDR_W = 28,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned LATENCY      = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [BLOCK_ADDR_W-1:0] ADDRESS,
    input  logic [127:0]            WRITEDATA,
`ifdef DMEM_BYTEEN_EN
    input  logic [15:0]             BYTEEN,
`endif
    output logic [127:0]            READDATA,
    output logic                    BUSYWAIT,
    output logic                    ERROR
);

    localparam int unsigned LINE_W = 128;
    localparam int unsigned BYTES  = LINE_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_count;
    logic                    r_is_write;
    logic [BLOCK_ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0]       r_wdata;
    logic [BYTES-1:0]        r_byteen;
    logic [LINE_W-1:0]       r_readdata;
    logic                    r_error;
    logic [LINE_W-1:0]       r_mem [DEPTH];

    logic                    w_req;
    logic                    w_start;
    logic                    w_finish;
    logic                    w_in_range;
    logic [IDX_W-1:0]        w_idx;
    logic [BYTES-1:0]        w_byteen_in;

    assign w_req      = READ | WRITE;
    assign w_start    = (r_state == ST_IDLE) && w_req;
    assign w_finish   = (r_state == ST_ACCESS) && (r_count == '0);
    assign w_in_range = ({1'b0, r_addr} < (BLOCK_ADDR_W + 1)'(DEPTH));
    assign w_idx      = r_addr[IDX_W-1:0];

`ifdef DMEM_BYTEEN_EN
    assign w_byteen_in = BYTEEN;
`else
    assign w_byteen_in = {BYTES{1'b1}};
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE after one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (r_count == '0) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: IDLE stalls combinationally on a pending request
    always_comb begin
        BUSYWAIT = 1'b0;
        case (r_state)
            ST_IDLE:   BUSYWAIT = w_req;
            ST_ACCESS: BUSYWAIT = 1'b1;
            ST_DONE:   BUSYWAIT = 1'b0;
            default:   BUSYWAIT = 1'b0;
        endcase
    end

    // Request capture and ACCESS countdown; write wins over simultaneous read
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_count    <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byteen   <= '0;
        end else if (w_start) begin
            r_count    <= CNT_W'(LATENCY - 1);
            r_is_write <= WRITE;
            r_addr     <= ADDRESS;
            r_wdata    <= WRITEDATA;
            r_byteen   <= w_byteen_in;
        end else if ((r_state == ST_ACCESS) && (r_count != '0)) begin
            r_count    <= r_count - CNT_W'(1);
        end
    end

    // Completion: read data and one-cycle out-of-range flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_readdata <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= w_finish && !w_in_range;
            if (w_finish) begin
                if (!w_in_range) begin
                    r_readdata <= '0;
                end else if (!r_is_write) begin
                    r_readdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Line storage; deliberately not reset
    always_ff @(posedge CLK) begin
        if (w_finish && r_is_write && w_in_range) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (r_byteen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign READDATA = r_readdata;
    assign ERROR    = r_error;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed testbench for data_memory_responder (LATENCY=5, DEPTH=256).
module tb_data_memory_responder;

    logic         clk;
    logic         rst_n;
    logic         rd_i;
    logic         wr_i;
    logic [27:0]  addr_i;
    logic [127:0] wdata_i;
`ifdef DMEM_BYTEEN_EN
    logic [15:0]  byteen_i;
`endif
    logic [127:0] readdata;
    logic         busy;
    logic         error;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = {16{8'hAA}};
    localparam logic [127:0] V0 = 128'h30303030_5A5A5A5A_C3C3C3C3_0F0F0F0F;
    localparam logic [127:0] VX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] VE = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    data_memory_responder #(
        .BLOCK_ADDR_W(28),
        .DEPTH(256),
        .LATENCY(5)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .READ(rd_i),
        .WRITE(wr_i),
        .ADDRESS(addr_i),
        .WRITEDATA(wdata_i),
`ifdef DMEM_BYTEEN_EN
        .BYTEEN(byteen_i),
`endif
        .READDATA(readdata),
        .BUSYWAIT(busy),
        .ERROR(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction; drop_at>0 releases READ/WRITE after that many stalled samples
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd, input int drop_at,
                       output int stalls, output logic [127:0] rdat,
                       output logic err, output logic err_after);
        bit done;
        stalls = 0; done = 1'b0; rdat = '0; err = 1'b0; err_after = 1'b0;
        @(posedge clk); #1;
        rd_i = rd; wr_i = wr; addr_i = addr; wdata_i = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy) begin
                stalls++;
                if (drop_at != 0 && stalls == drop_at) begin
                    rd_i = 1'b0; wr_i = 1'b0;
                end
            end else begin
                done = 1'b1; rdat = readdata; err = error;
            end
        end
        rd_i = 1'b0; wr_i = 1'b0;
        if (!done) check_eq("timeout", 128'd0, 128'd1);
        @(negedge clk);
        err_after = error;
    endtask

    int           st;
    logic [127:0] rdv;
    logic         ev, ea;

    initial begin
        rst_n = 1'b0; rd_i = 1'b0; wr_i = 1'b0; addr_i = '0; wdata_i = '0;
`ifdef DMEM_BYTEEN_EN
        byteen_i = 16'hFFFF;
`endif
        #12;
        check_eq("rst_readdata", readdata, 128'd0);
        check_eq("rst_error", 128'(error), 128'd0);
        check_eq("rst_busy_idle", 128'(busy), 128'd0);
        rd_i = 1'b1; #1;
        check_eq("rst_busy_follows_read", 128'(busy), 128'd1);
        @(posedge clk); @(posedge clk); #1;
        rd_i = 1'b0; #1;
        check_eq("rst_no_txn_started", 128'(busy), 128'd0);
        @(negedge clk); rst_n = 1'b1;

        // Plain write then read back
        txn(1'b0, 1'b1, 28'h10, D1, 0, st, rdv, ev, ea);
        check_eq("wr10_stalls", 128'(st), 128'd6);
        check_eq("wr10_readdata_kept", rdv, 128'd0);
        check_eq("wr10_error", 128'(ev), 128'd0);
        txn(1'b1, 1'b0, 28'h10, '0, 0, st, rdv, ev, ea);
        check_eq("rd10_stalls", 128'(st), 128'd6);
        check_eq("rd10_data", rdv, D1);
        check_eq("rd10_error", 128'(ev), 128'd0);

        // READ and WRITE together: write wins, READDATA untouched
        txn(1'b1, 1'b1, 28'h20, DA, 0, st, rdv, ev, ea);
        check_eq("both20_readdata_kept", rdv, D1);
        txn(1'b1, 1'b0, 28'h20, '0, 0, st, rdv, ev, ea);
        check_eq("rd20_data", rdv, DA);

        // Out-of-range read
        txn(1'b1, 1'b0, 28'h100, '0, 0, st, rdv, ev, ea);
        check_eq("oor_stalls", 128'(st), 128'd6);
        check_eq("oor_error_done", 128'(ev), 128'd1);
        check_eq("oor_readdata", rdv, 128'd0);
        check_eq("oor_error_after", 128'(ea), 128'd0);

        // Last valid line: no error
        txn(1'b0, 1'b1, 28'hFF, VE, 0, st, rdv, ev, ea);
        txn(1'b1, 1'b0, 28'hFF, '0, 0, st, rdv, ev, ea);
        check_eq("rdff_data", rdv, VE);
        check_eq("rdff_error", 128'(ev), 128'd0);

        // Reset during the 3rd ACCESS cycle aborts the write
        txn(1'b0, 1'b1, 28'h30, V0, 0, st, rdv, ev, ea);
        txn(1'b1, 1'b0, 28'h20, '0, 0, st, rdv, ev, ea);
        check_eq("pre_rst_readdata", rdv, DA);
        @(posedge clk); #1;
        wr_i = 1'b1; addr_i = 28'h30; wdata_i = VX;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; wr_i = 1'b0; #1;
        check_eq("midrst_busy", 128'(busy), 128'd0);
        check_eq("midrst_readdata", readdata, 128'd0);
        check_eq("midrst_error", 128'(error), 128'd0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        txn(1'b1, 1'b0, 28'h30, '0, 0, st, rdv, ev, ea);
        check_eq("rd30_prewrite_value", rdv, V0);

        // READ dropped after one ACCESS cycle still completes, once
        txn(1'b1, 1'b0, 28'h10, '0, 2, st, rdv, ev, ea);
        check_eq("drop_stalls", 128'(st), 128'd6);
        check_eq("drop_data", rdv, D1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("drop_no_second_txn", 128'(busy), 128'd0);
        end

`ifdef DMEM_BYTEEN_EN
        byteen_i = 16'hFFFF;
        txn(1'b0, 1'b1, 28'h40, {16{8'hFF}}, 0, st, rdv, ev, ea);
        byteen_i = 16'h000F;
        txn(1'b0, 1'b1, 28'h40, 128'd0, 0, st, rdv, ev, ea);
        byteen_i = 16'h0000;
        txn(1'b0, 1'b1, 28'h40, 128'd0, 0, st, rdv, ev, ea);
        check_eq("be0_stalls", 128'(st), 128'd6);
        byteen_i = 16'hFFFF;
        txn(1'b1, 1'b0, 28'h40, '0, 0, st, rdv, ev, ea);
        check_eq("byteen_data", rdv, {{12{8'hFF}}, 32'h0});
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
